// File: rtl/alu_share_ctrl.sv
// Two-way round-robin arbiter and sequencer in front of a shared combinational ALU.
// Define ALU_OPCHECK_EN to answer ops 6/7 directly with rsp_err instead of running the ALU.
module alu_share_ctrl #(
    parameter int unsigned MUL_LATENCY  = 3,
    parameter int unsigned BASE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_set,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        flag_z,
    output logic        flag_n,
    output logic        busy,
    output logic [31:0] alu_dat1,
    output logic [31:0] alu_dat2,
    output logic [2:0]  alu_control,
    output logic        alu_set,
    input  logic [31:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_n
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] MUL_LAT  = 4'(MUL_LATENCY);
    localparam logic [3:0] BASE_LAT = 4'(BASE_LATENCY);
    localparam logic [2:0] OP_MUL   = 3'd2;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_err_q, rsp_err_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;
    logic        busy_q, busy_d;
    logic [31:0] alu_dat1_q, alu_dat1_d;
    logic [31:0] alu_dat2_q, alu_dat2_d;
    logic [2:0]  alu_control_q, alu_control_d;
    logic        alu_set_q, alu_set_d;

    logic        grant_any_s;
    logic        grant_idx_s;
    logic [2:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic        sel_set_s;
    logic        illegal_s;
    logic        unused_alu_flags_s;

    // Flags are recomputed from alu_result, so the ALU's own Z/N are not consumed.
    assign unused_alu_flags_s = alu_z ^ alu_n;

    // Round-robin arbitration: a lone requester wins, a tie goes to the priority pointer.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = 1'b0;
        case (req_valid)
            2'b01:   begin grant_any_s = 1'b1; grant_idx_s = 1'b0;   end
            2'b10:   begin grant_any_s = 1'b1; grant_idx_s = 1'b1;   end
            2'b11:   begin grant_any_s = 1'b1; grant_idx_s = prio_q; end
            default: begin grant_any_s = 1'b0; grant_idx_s = 1'b0;   end
        endcase
    end

    assign sel_op_s  = grant_idx_s ? req_op[5:3]   : req_op[2:0];
    assign sel_a_s   = grant_idx_s ? req_a[63:32]  : req_a[31:0];
    assign sel_b_s   = grant_idx_s ? req_b[63:32]  : req_b[31:0];
    assign sel_set_s = grant_idx_s ? req_set[1]    : req_set[0];

`ifdef ALU_OPCHECK_EN
    assign illegal_s = (sel_op_s == 3'd6) || (sel_op_s == 3'd7);
`else
    assign illegal_s = 1'b0;
`endif

    // Accept is combinational so a requester sees ready in the same cycle it raises valid.
    assign req_ready = (state_q == IDLE && grant_any_s && !reset)
                       ? (grant_idx_s ? 2'b10 : 2'b01) : 2'b00;

    // Next-state and next-output computation for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        prio_d        = prio_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_err_d     = rsp_err_q;
        flag_z_d      = flag_z_q;
        flag_n_d      = flag_n_q;
        alu_dat1_d    = alu_dat1_q;
        alu_dat2_d    = alu_dat2_q;
        alu_control_d = alu_control_q;
        alu_set_d     = alu_set_q;
        case (state_q)
            IDLE: begin
                if (grant_any_s) begin
                    owner_d = grant_idx_s;
                    prio_d  = ~grant_idx_s;
                    if (illegal_s) begin
                        state_d      = RESP;
                        rsp_result_d = 32'hFFFF_FFFF;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = grant_idx_s ? 2'b10 : 2'b01;
                    end else begin
                        state_d       = EXEC;
                        rsp_err_d     = 1'b0;
                        alu_dat1_d    = sel_a_s;
                        alu_dat2_d    = sel_b_s;
                        alu_control_d = sel_op_s;
                        alu_set_d     = sel_set_s;
                        cnt_d         = (sel_op_s == OP_MUL) ? MUL_LAT : BASE_LAT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                    if (alu_set_q) begin
                        flag_z_d = (alu_result == 32'd0);
                        flag_n_d = alu_result[31];
                    end else begin
                        flag_z_d = flag_z_q;
                        flag_n_d = flag_n_q;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            owner_q       <= 1'b0;
            prio_q        <= 1'b0;
            rsp_valid_q   <= 2'b00;
            rsp_result_q  <= 32'd0;
            rsp_err_q     <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_n_q      <= 1'b0;
            busy_q        <= 1'b0;
            alu_dat1_q    <= 32'd0;
            alu_dat2_q    <= 32'd0;
            alu_control_q <= 3'd0;
            alu_set_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            prio_q        <= prio_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_err_q     <= rsp_err_d;
            flag_z_q      <= flag_z_d;
            flag_n_q      <= flag_n_d;
            busy_q        <= busy_d;
            alu_dat1_q    <= alu_dat1_d;
            alu_dat2_q    <= alu_dat2_d;
            alu_control_q <= alu_control_d;
            alu_set_q     <= alu_set_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign busy        = busy_q;
    assign alu_dat1    = alu_dat1_q;
    assign alu_dat2    = alu_dat2_q;
    assign alu_control = alu_control_q;
    assign alu_set     = alu_set_q;
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer and two-way round-robin arbiter in front of the shared combinational ALU (control codes: 0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr).
- Accepts operation requests from two requesters (e.g. the key-decode FSM and the display/convert unit) over valid/ready.
- Drives the ALU operands, control and set inputs, holds them stable for a per-op latency, then returns the result to the owning requester.
- Keeps the architectural Z/N flag register.

Parameters:
- MUL_LATENCY, 3, cycles the ALU inputs are held for op 2 (mul). Legal range 1..15.
- BASE_LATENCY, 1, cycles held for all other ops. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_op  in  6  {op1[2:0], op0[2:0]}
- req_a  in  64  {a1, a0}; 32 bits each
- req_b  in  64  {b1, b0}; 32 bits each
- req_set  in  2  per-requester "update flags" bit
- rsp_valid  out  2  result valid to owner; at most one bit high
- rsp_ready  in  2  per-requester result accept
- rsp_result  out  32  result to owner
- rsp_err  out  1  illegal-op indication (see Optional Feature)
- flag_z  out  1  registered zero flag
- flag_n  out  1  registered negative flag
- busy  out  1  high whenever state != IDLE
- alu_dat1  out  32  ALU operand 1
- alu_dat2  out  32  ALU operand 2
- alu_control  out  3  ALU op select
- alu_set  out  1  ALU set input
- alu_result  in  32  ALU result
- alu_z  in  1  ALU Z output (ignored; flags derived internally)
- alu_n  in  1  ALU N output (ignored)

Behaviour:
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_result 0, rsp_err 0, flag_z 0, flag_n 0, busy 0, alu_* 0, priority pointer = requester 0, latency counter 0, owner 0.
- Reset mid-operation abandons the transaction: no response, flags unchanged from reset values, outputs return to reset values next edge.
- Registered FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the single requesting bit, or the priority bit if both are set.
  - req_ready is combinational from state==IDLE plus arbitration, so it is high in the same cycle as req_valid.
  - On that edge: latch op/a/b/set and owner; load counter = (op==2) ? MUL_LATENCY : BASE_LATENCY; set priority = other requester; go to EXEC.
- Priority flips only on grant. A lone requester may be granted back-to-back.
- EXEC:
  - alu_dat1/alu_dat2/alu_control/alu_set are driven from latched values and stay constant throughout.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture alu_result into rsp_result; go to RESP.
  - If latched set = 1, also update flag_n = result[31] and flag_z = (result == 0). If set = 0, flags hold.
- RESP:
  - rsp_valid[owner] = 1 until rsp_ready[owner] is sampled high; then go to IDLE.
  - rsp_result is stable while valid. rsp_ready from the non-owner is ignored.
  - No new request is accepted in RESP; IDLE accept is the earliest (no bypass).
- Latency: accept at edge T; rsp_valid visible after edge T+L, where L = BASE_LATENCY or MUL_LATENCY.
- Throughput: one op per L+2 cycles with rsp_ready tied high.
- Arithmetic is the ALU's: 32-bit wraparound; mul keeps the low 32 bits; shifts by ≥32 give 0.
- alu_* hold their last value in IDLE/RESP (no toggling).

Optional Feature:
- ALU_OPCHECK_EN defined:
  - Ops 6 and 7 are accepted but skip EXEC: IDLE -> RESP directly.
  - rsp_result = 32'hFFFFFFFF, rsp_err = 1 during that RESP, flags unchanged, ALU not driven.
  - rsp_err = 0 for legal ops.
- ALU_OPCHECK_EN undefined:
  - Ops 6/7 are sequenced like others with BASE_LATENCY.
  - Result is whatever the ALU returns (FFFFFFFF default); flags update per set.
  - rsp_err tied 0.

Test Plan:
- Reset, then requester 0 add a=5 b=7 set=1, rsp_ready=1 -> rsp_valid[0] after 1 cycle of EXEC; rsp_result=12; flag_z=0, flag_n=0; busy low after handshake.
- Requester 1 sub a=3 b=3 set=1, then sub a=1 b=2 set=0 -> first: result 0, flag_z=1. Second: result FFFFFFFF, flags still z=1, n=0.
- Both valid continuously, 4 ops each -> grants alternate 0,1,0,1,…; never two req_ready bits high; no starvation.
- MUL_LATENCY=3, mul a=0x10000 b=0x10000 -> alu_control=2 held for 3 cycles; result 0 (wrap); rsp_valid at T+3.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_result stable; the other requester's valid gets no req_ready until the handshake completes.
- Assert reset during EXEC of a mul -> no rsp_valid, all outputs at reset values next cycle. With ALU_OPCHECK_EN, op 7 -> rsp_err=1, result FFFFFFFF, one cycle after accept.
